// File: rtl/seq_divider_if.sv
// Request/result bundle between the ALU control unit (master) and the divider (slave).
// Operands and mode are sampled with start; results are valid while done is high.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, signed_op, X, Y,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, signed_op, X, Y,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential radix-2 non-restoring divider on magnitudes with sign fix-up,
// signed/unsigned per operation, start/done handshake.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_CORR,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] x_r, y_r;
    logic             sop_r;
    logic [WIDTH:0]   A, M;
    logic [WIDTH-1:0] Q;
    logic             neg_q, neg_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             div_zero_r;

    logic             y_zero;
    logic [WIDTH-1:0] x_abs, y_abs;
    logic [WIDTH:0]   a_shift, a_next, a_corr;

    always_comb begin
        y_zero  = (y_r == '0);
        x_abs   = (sop_r && x_r[WIDTH-1]) ? -x_r : x_r;
        y_abs   = (sop_r && y_r[WIDTH-1]) ? -y_r : y_r;
        a_shift = {A[WIDTH-1:0], Q[WIDTH-1]};
        // Sign of the old partial remainder picks subtract vs add-back.
        a_next  = A[WIDTH] ? (a_shift + M) : (a_shift - M);
        a_corr  = A[WIDTH] ? (A + M) : A;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = S_LOAD;
            end
            S_LOAD: state_next = y_zero ? S_DONE : S_ITER;
            S_ITER: if (cnt == LAST) state_next = S_CORR;
            S_CORR: state_next = S_DONE;
            S_DONE: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Results are written on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r         <= '0;
            y_r         <= '0;
            sop_r       <= 1'b0;
            A           <= '0;
            Q           <= '0;
            M           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x_r   <= bus.X;
                        y_r   <= bus.Y;
                        sop_r <= bus.signed_op;
                    end
                end
                S_LOAD: begin
                    if (y_zero) begin
                        quotient_r  <= '1;
                        remainder_r <= x_r;
                        div_zero_r  <= 1'b1;
                    end else begin
                        A     <= '0;
                        Q     <= x_abs;
                        M     <= {1'b0, y_abs};
                        neg_q <= sop_r & (x_r[WIDTH-1] ^ y_r[WIDTH-1]);
                        neg_r <= sop_r & x_r[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                S_ITER: begin
                    A   <= a_next;
                    Q   <= {Q[WIDTH-2:0], ~a_next[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                S_CORR: begin
                    A           <= a_corr;
                    quotient_r  <= neg_q ? -Q : Q;
                    remainder_r <= neg_r ? -a_corr[WIDTH-1:0] : a_corr[WIDTH-1:0];
                    div_zero_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
endmodule
